// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm controller.
//   state_e        : controller states
//   HH/MM/SS slices: field positions inside a 24-bit BCD HH:MM:SS word
//   bcd_time_valid : true when a BCD word is a legal 24-hour time
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } state_e;

  localparam int HH_MSB = 23;
  localparam int HH_LSB = 16;
  localparam int MM_MSB = 15;
  localparam int MM_LSB = 8;
  localparam int SS_MSB = 7;
  localparam int SS_LSB = 0;

  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic [7:0] hh, mm, ss;
    hh = t[HH_MSB:HH_LSB];
    mm = t[MM_MSB:MM_LSB];
    ss = t[SS_MSB:SS_LSB];
    // Any digit pattern outside 00:00:00 .. 23:59:59 is rejected.
    if (hh[7:4] > 4'd2)                       return 1'b0;
    if (hh[7:4] == 4'd2 && hh[3:0] > 4'd3)    return 1'b0;
    if (mm[7:4] > 4'd5 || ss[7:4] > 4'd5)     return 1'b0;
    if (hh[3:0] > 4'd9 || mm[3:0] > 4'd9 || ss[3:0] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/alarm_tick_counter.sv
// Loadable saturating counter stepped by the 1 s tick.
//   clk, rst  : clock, async active-high reset (count returns to 0)
//   load      : load load_val (wins over step)
//   load_val  : value to load
//   step      : advance one position (up or down, fixed by UP)
//   target    : terminal value
//   hit       : this step lands the count on target
module alarm_tick_counter #(
  parameter int W  = 8,
  parameter bit UP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] target,
  output logic         hit
);

  logic [W-1:0] cnt_q, cnt_d, cnt_nxt;

  always_comb begin
    // Saturate at either end so the count never wraps.
    if (UP) cnt_nxt = (cnt_q == {W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    else    cnt_nxt = (cnt_q == '0)        ? cnt_q : cnt_q - 1'b1;

    cnt_d = cnt_q;
    if (load)      cnt_d = load_val;
    else if (step) cnt_d = cnt_nxt;

    hit = step && !load && (cnt_nxt == target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm controller fed by the clock block's BCD time word.
//   clk, rst       : clock, async active-high reset
//   tick_1s        : one-cycle pulse per second
//   time_bcd       : running time, BCD HH:MM:SS
//   alarm_set_bcd  : candidate alarm time, loaded by set_alarm
//   set_alarm, arm_toggle, snooze, dismiss : one-cycle command pulses
//   alarm_bcd      : stored alarm time
//   armed, ringing : state indicators
//   buzzer         : tone enable, toggled each second while ringing
//   snoozes_left   : snoozes still available for the current event
//   set_err        : one-cycle pulse for a rejected set_alarm
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_SEC  = 300,
  parameter int MAX_SNOOZES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1s,
  input  logic [23:0] time_bcd,
  input  logic [23:0] alarm_set_bcd,
  input  logic        set_alarm,
  input  logic        arm_toggle,
  input  logic        snooze,
  input  logic        dismiss,
  output logic [23:0] alarm_bcd,
  output logic        armed,
  output logic        ringing,
  output logic        buzzer,
  output logic [1:0]  snoozes_left,
  output logic        set_err
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_T  = CW'(RING_SEC);
  localparam logic [CW-1:0] SNZ_T   = CW'(SNOOZE_SEC);
  localparam logic [1:0]    MAX_SNZ = 2'(MAX_SNOOZES);

  state_e      state_q, state_d;
  logic [23:0] alarm_q, alarm_d;
  logic        buzzer_q, buzzer_d;
  logic        set_err_q, set_err_d;
  logic [1:0]  left_q, left_d;
  logic        match_q, match, rise;

  logic ring_load, ring_step, ring_hit;
  logic snz_load, snz_step, snz_hit;

  assign match = (time_bcd == alarm_q);
  assign rise  = match & ~match_q;

  alarm_tick_counter #(.W(CW), .UP(1'b1)) u_ring_cnt (
    .clk(clk), .rst(rst), .load(ring_load), .load_val('0),
    .step(ring_step), .target(RING_T), .hit(ring_hit)
  );

  alarm_tick_counter #(.W(CW), .UP(1'b0)) u_snz_cnt (
    .clk(clk), .rst(rst), .load(snz_load), .load_val(SNZ_T),
    .step(snz_step), .target('0), .hit(snz_hit)
  );

  always_comb begin
    state_d   = state_q;
    alarm_d   = alarm_q;
    buzzer_d  = buzzer_q;
    set_err_d = 1'b0;
    left_d    = left_q;
    ring_load = 1'b0;
    ring_step = 1'b0;
    snz_load  = 1'b0;
    snz_step  = 1'b0;

    // One command acts per cycle; a command that does not apply in the
    // current state falls through so it cannot swallow a tick or a match.
    if (set_alarm) begin
      if (bcd_time_valid(alarm_set_bcd)) begin
        alarm_d = alarm_set_bcd;
        if (state_q == ST_RINGING || state_q == ST_SNOOZING) state_d = ST_ARMED;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (arm_toggle) begin
      state_d = (state_q == ST_DISARMED) ? ST_ARMED : ST_DISARMED;
    end else if (dismiss && (state_q == ST_RINGING || state_q == ST_SNOOZING)) begin
      state_d = ST_ARMED;
    end else if (snooze && state_q == ST_RINGING && left_q != 2'd0) begin
      state_d  = ST_SNOOZING;
      snz_load = 1'b1;
      left_d   = left_q - 2'd1;
    end else begin
      unique case (state_q)
        ST_ARMED: if (rise) begin
          // A tick landing here is not counted: the counter is just loaded.
          state_d   = ST_RINGING;
          ring_load = 1'b1;
          buzzer_d  = 1'b1;
          left_d    = MAX_SNZ;
        end
        ST_RINGING: if (tick_1s) begin
          ring_step = 1'b1;
          buzzer_d  = ~buzzer_q;
          if (ring_hit) state_d = ST_ARMED;
        end
        ST_SNOOZING: if (tick_1s) begin
          snz_step = 1'b1;
          if (snz_hit) begin
            state_d   = ST_RINGING;
            ring_load = 1'b1;
            buzzer_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_d != ST_RINGING) buzzer_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISARMED;
      alarm_q   <= 24'h000000;
      buzzer_q  <= 1'b0;
      set_err_q <= 1'b0;
      left_q    <= MAX_SNZ;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      buzzer_q  <= buzzer_d;
      set_err_q <= set_err_d;
      left_q    <= left_d;
      match_q   <= match;
    end
  end

  assign alarm_bcd    = alarm_q;
  assign armed        = (state_q != ST_DISARMED);
  assign ringing      = (state_q == ST_RINGING);
  assign buzzer       = buzzer_q;
  assign snoozes_left = left_q;
  assign set_err      = set_err_q;

endmodule

// File: tb/tb_alarm_unit.sv
module tb_alarm_unit;

  logic        clk, rst, tick_1s, set_alarm, arm_toggle, snooze, dismiss;
  logic [23:0] time_bcd, alarm_set_bcd, alarm_bcd;
  logic        armed, ringing, buzzer, set_err;
  logic [1:0]  snoozes_left;

  int n_cmp, n_bad;

  alarm_unit #(.RING_SEC(4), .SNOOZE_SEC(2), .MAX_SNOOZES(3)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .time_bcd(time_bcd),
    .alarm_set_bcd(alarm_set_bcd), .set_alarm(set_alarm),
    .arm_toggle(arm_toggle), .snooze(snooze), .dismiss(dismiss),
    .alarm_bcd(alarm_bcd), .armed(armed), .ringing(ringing),
    .buzzer(buzzer), .snoozes_left(snoozes_left), .set_err(set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sa, at, sn, di, tk;
    logic [23:0] tm, as;
    logic        e_armed, e_ring, e_buz;
    logic [1:0]  e_left;
    logic        e_err;
    logic [23:0] e_al;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sa, at, sn, di, tk, input logic [23:0] tm, as,
                     input logic e_armed, e_ring, e_buz, input logic [1:0] e_left,
                     input logic e_err, input logic [23:0] e_al);
    vec_t v;
    v.sa = sa; v.at = at; v.sn = sn; v.di = di; v.tk = tk; v.tm = tm; v.as = as;
    v.e_armed = e_armed; v.e_ring = e_ring; v.e_buz = e_buz;
    v.e_left = e_left; v.e_err = e_err; v.e_al = e_al;
    vq.push_back(v);
  endtask

  task automatic drive(input logic sa, at, sn, di, tk, input logic [23:0] tm, as);
    @(negedge clk);
    set_alarm = sa; arm_toggle = at; snooze = sn; dismiss = di; tick_1s = tk;
    time_bcd = tm; alarm_set_bcd = as;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_armed, e_ring, e_buz,
                       input logic [1:0] e_left, input logic e_err, input logic [23:0] e_al);
    n_cmp++;
    if (armed !== e_armed || ringing !== e_ring || buzzer !== e_buz ||
        snoozes_left !== e_left || set_err !== e_err || alarm_bcd !== e_al) begin
      n_bad++;
      $display("FAIL %s: got armed=%b ring=%b buz=%b left=%0d err=%b al=%h, want armed=%b ring=%b buz=%b left=%0d err=%b al=%h",
               name, armed, ringing, buzzer, snoozes_left, set_err, alarm_bcd,
               e_armed, e_ring, e_buz, e_left, e_err, e_al);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; tick_1s = 1'b0; set_alarm = 1'b0; arm_toggle = 1'b0;
    snooze = 1'b0; dismiss = 1'b0; time_bcd = 24'h065959; alarm_set_bcd = 24'h0;

    //   sa at sn di tk  time        set          armed ring buz left err alarm
    add(1, 0, 0, 0, 0, 24'h065959, 24'h246000, 0, 0, 0, 3, 1, 24'h000000);
    add(1, 0, 0, 0, 0, 24'h065959, 24'h240000, 0, 0, 0, 3, 1, 24'h000000);
    add(1, 0, 0, 0, 0, 24'h065959, 24'h1f0000, 0, 0, 0, 3, 1, 24'h000000);
    add(1, 0, 0, 0, 0, 24'h065959, 24'h095960, 0, 0, 0, 3, 1, 24'h000000);
    add(1, 0, 0, 0, 0, 24'h065959, 24'h235959, 0, 0, 0, 3, 0, 24'h235959);
    add(1, 0, 0, 0, 0, 24'h065959, 24'h070000, 0, 0, 0, 3, 0, 24'h070000);
    add(0, 1, 0, 0, 0, 24'h065959, 24'h0,      1, 0, 0, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h065959, 24'h0,      1, 0, 0, 3, 0, 24'h070000);
    // match arrives with a tick: ring starts, tick not counted
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 0, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 0, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 0, 0, 3, 0, 24'h070000);
    // held match does not re-ring; a fresh match does
    add(0, 0, 0, 0, 0, 24'h070000, 24'h0,      1, 0, 0, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h070001, 24'h0,      1, 0, 0, 3, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    // three snoozes, each re-rings after two ticks
    add(0, 0, 1, 0, 0, 24'h070000, 24'h0,      1, 0, 0, 2, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 0, 0, 2, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 1, 2, 0, 24'h070000);
    add(0, 0, 1, 0, 0, 24'h070000, 24'h0,      1, 0, 0, 1, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 0, 0, 1, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 1, 1, 0, 24'h070000);
    add(0, 0, 1, 0, 0, 24'h070000, 24'h0,      1, 0, 0, 0, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 0, 0, 0, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 1, 0, 0, 24'h070000);
    add(0, 0, 1, 0, 0, 24'h070000, 24'h0,      1, 1, 1, 0, 0, 24'h070000);
    add(0, 0, 0, 0, 1, 24'h070000, 24'h0,      1, 1, 0, 0, 0, 24'h070000);
    // arm_toggle beats dismiss
    add(0, 1, 0, 1, 0, 24'h070000, 24'h0,      0, 0, 0, 0, 0, 24'h070000);
    // arming onto an existing match does not ring
    add(0, 1, 0, 0, 0, 24'h070000, 24'h0,      1, 0, 0, 0, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h065959, 24'h0,      1, 0, 0, 0, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    // snooze beats tick; then dismiss out of snooze
    add(0, 0, 1, 0, 1, 24'h070000, 24'h0,      1, 0, 0, 2, 0, 24'h070000);
    add(0, 0, 0, 1, 0, 24'h070000, 24'h0,      1, 0, 0, 2, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h065959, 24'h0,      1, 0, 0, 2, 0, 24'h070000);
    add(0, 0, 0, 0, 0, 24'h070000, 24'h0,      1, 1, 1, 3, 0, 24'h070000);
    // valid set while ringing forces ARMED
    add(1, 0, 0, 0, 0, 24'h070000, 24'h123456, 1, 0, 0, 3, 0, 24'h123456);

    #3;
    check("reset_state", 0, 0, 0, 3, 0, 24'h000000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].sa, vq[i].at, vq[i].sn, vq[i].di, vq[i].tk, vq[i].tm, vq[i].as);
      check($sformatf("vec%0d", i), vq[i].e_armed, vq[i].e_ring, vq[i].e_buz,
            vq[i].e_left, vq[i].e_err, vq[i].e_al);
    end

    // asynchronous reset while snoozing, between clock edges
    drive(0, 0, 0, 0, 0, 24'h123455, 24'h0);
    drive(0, 0, 0, 0, 0, 24'h123456, 24'h0);
    check("ring_new_alarm", 1, 1, 1, 3, 0, 24'h123456);
    drive(0, 0, 1, 0, 0, 24'h123456, 24'h0);
    check("snooze_before_rst", 1, 0, 0, 2, 0, 24'h123456);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 0, 0, 3, 0, 24'h000000);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 24'h000000, 24'h0);
    check("after_rst", 0, 0, 0, 3, 0, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm controller that sits directly downstream of the clock block and consumes its 24-bit BCD HH:MM:SS time word. It holds a programmable alarm time and compares it against the running time. On a match it rings a 1 Hz-gated buzzer, and it manages snooze, dismiss and auto-stop using the same one-second tick that advances the clock.

## Interface
Parameters:
- RING_SEC, default 60: ticks of ringing before auto-stop.
- SNOOZE_SEC, default 300: ticks spent in snooze before re-ringing.
- MAX_SNOOZES, default 3: snoozes allowed per alarm event.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- tick_1s, input, 1: single-cycle pulse once per second, the same tick that advances the clock.
- time_bcd, input, 24: current time as BCD HH:MM:SS, with bits [23:20] holding the hours tens digit.
- alarm_set_bcd, input, 24: candidate alarm time, in the same format.
- set_alarm, input, 1: pulse that loads alarm_set_bcd.
- arm_toggle, input, 1: pulse that arms or disarms the alarm.
- snooze, input, 1: pulse that requests a snooze.
- dismiss, input, 1: pulse that stops ringing or snoozing.
- alarm_bcd, output, 24: stored alarm time.
- armed, output, 1: high in every state except DISARMED.
- ringing, output, 1: high in RINGING.
- buzzer, output, 1: 1 Hz-gated tone enable.
- snoozes_left, output, 2: remaining snoozes for the current event.
- set_err, output, 1: one-cycle pulse when set_alarm carries an invalid time.

## Operation
- States: DISARMED, ARMED, RINGING, SNOOZING.
- Reset values: state DISARMED, alarm_bcd 24'h000000, buzzer 0, ringing 0, set_err 0, snoozes_left MAX_SNOOZES, all counters 0, match_q 0.
- Match detection: match = (time_bcd == alarm_bcd); match_q is match registered each cycle; rise = match & ~match_q. A held match re-triggers nothing.
- Transitions:
  - DISARMED --arm_toggle--> ARMED.
  - ARMED --arm_toggle--> DISARMED.
  - ARMED --rise--> RINGING. Entry loads ring_cnt=0, buzzer=1, snoozes_left=MAX_SNOOZES.
  - RINGING --snooze and snoozes_left>0--> SNOOZING. Entry loads snz_cnt=SNOOZE_SEC, decrements snoozes_left, sets buzzer=0.
  - RINGING --snooze and snoozes_left==0--> no change; the snooze is ignored.
  - RINGING: on each tick_1s, ring_cnt increments and buzzer toggles. When the tick brings ring_cnt to RING_SEC, go to ARMED.
  - SNOOZING: on each tick_1s, snz_cnt decrements. When the tick brings it to 0, go to RINGING with ring_cnt=0, buzzer=1, and snoozes_left preserved.
  - RINGING or SNOOZING --dismiss--> ARMED.
  - RINGING or SNOOZING --arm_toggle--> DISARMED.
- Same-cycle priority: set_alarm, then arm_toggle, then dismiss, then snooze, then tick and rise events.
- set_alarm with a valid value: load alarm_bcd. If the state is RINGING or SNOOZING, force ARMED. Otherwise the state is unchanged.
- set_alarm with an invalid value: alarm_bcd is unchanged and set_err pulses for one cycle. A value is invalid when any of these holds:
  - H tens > 2.
  - HH > 23.
  - M tens or S tens > 5.
  - Any units digit > 9.
- Outside RINGING, buzzer is forced to 0.
- Arithmetic: ring_cnt and snz_cnt are $clog2(max(RING_SEC,SNOOZE_SEC)+1) bits wide and never wrap. snoozes_left saturates at 0.

## Timing
- All outputs are registered.
- Latency:
  - ringing and buzzer rise 1 clk after time_bcd first presents the alarm value.
  - set_err is high on the cycle after set_alarm.
  - alarm_bcd updates 1 clk after set_alarm.
- If tick_1s coincides with RINGING entry, that tick does not count.
- A match that is already present at the cycle arm_toggle arms the unit does not ring, because match_q was already high.
- Reset mid-operation: asynchronous return to the reset values. The stored alarm_bcd is lost.

## Structure
- alarm_pkg holds:
  - the state enum;
  - localparams for the field slices HH=[23:16], MM=[15:8], SS=[7:0];
  - function bcd_time_valid(logic [23:0]).
- One sub-module, alarm_tick_counter: a loadable up/down counter with terminal flag, instantiated twice (ring in up mode, snooze in down mode).

## Test plan
- Reset, then arm, set alarm to 24'h070000, and drive time_bcd from 24'h065959 to 24'h070000. Expect ringing=1 and buzzer=1 exactly 1 clk later; buzzer toggles on each tick_1s.
- With RING_SEC=4, let the alarm ring with no input. Expect state ARMED after the 4th tick, with buzzer=0. Holding time at 24'h070000 does not re-trigger.
- With SNOOZE_SEC=2 and MAX_SNOOZES=3, snooze three times. Each snooze re-rings after 2 ticks, and snoozes_left counts 2, 1, 0. A 4th snooze is ignored and ringing stays 1.
- set_alarm with 24'h246000 leaves alarm_bcd unchanged and pulses set_err. set_alarm with 24'h235959 loads it.
- dismiss and arm_toggle in the same cycle while RINGING gives DISARMED. dismiss alone while SNOOZING gives ARMED with buzzer=0.
- Assert rst mid-SNOOZING, asynchronously between clock edges. All outputs immediately take their reset values; alarm_bcd=0 and armed=0.
